// File: rtl/fp_normalize_round.sv
// Post-datapath normalizer: aligns the extended mantissa, rounds to nearest-even
// and packs an IEEE-754 single-precision result with overflow/underflow flags.
module fp_normalize_round #(
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              nan_in,
    output logic [31:0]       R,
    output logic              done,
    output logic              overflow,
    output logic              underflow
);

    // Two guard bits on the working exponent so shifts and the rounding carry never wrap.
    localparam int unsigned XW     = EXP_W + 2;
    localparam int unsigned CARRY  = MANT_W - 1;
    localparam int unsigned HIDDEN = MANT_W - 2;

    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic signed [XW-1:0] EXP_INF = XW'(255);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_PACK,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic                 start_q;
    logic                 armed_q, armed_n;
    logic                 start_edge;
    logic                 sign_r, sign_n;
    logic                 nan_r, nan_n;
    logic                 inexact_r, inexact_n;
    logic signed [XW-1:0] exp_r, exp_n;
    logic [MANT_W-1:0]    mant_r, mant_n;
    logic [MANT_W-1:0]    rnd_sum;
    logic                 round_up;
    logic                 exp_lt1;
    logic [7:0]           field;
    logic [31:0]          r_n;
    logic                 done_n, ovf_n, unf_n;

    // A start already high when reset is released must drop once before it counts.
    assign start_edge = start & ~start_q & armed_q;
    assign exp_lt1    = (exp_r < EXP_ONE);

    // Next-state and datapath updates
    always_comb begin
        state_n   = state;
        armed_n   = armed_q | ~start;
        sign_n    = sign_r;
        nan_n     = nan_r;
        inexact_n = inexact_r;
        exp_n     = exp_r;
        mant_n    = mant_r;
        r_n       = R;
        done_n    = done;
        ovf_n     = overflow;
        unf_n     = underflow;
        rnd_sum   = '0;
        round_up  = 1'b0;
        field     = 8'h00;

        case (state)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    sign_n    = sign_in;
                    nan_n     = nan_in;
                    exp_n     = {{2{exp_in[EXP_W-1]}}, exp_in};
                    mant_n    = mant_in;
                    inexact_n = 1'b0;
                    done_n    = 1'b0;
                    ovf_n     = 1'b0;
                    unf_n     = 1'b0;
                    state_n   = S_NORM;
                end
            end

            S_NORM: begin
                if (nan_r || (mant_r == '0)) begin
                    state_n = S_PACK;
                end else if (exp_lt1 && (mant_r[CARRY:3] == '0)) begin
                    // Everything left sits below the guard bit: only stickiness survives.
                    mant_n = MANT_W'(|mant_r[2:0]);
                    exp_n  = EXP_ONE;
                end else if (mant_r[CARRY] || exp_lt1) begin
                    mant_n = {1'b0, mant_r[CARRY:2], mant_r[1] | mant_r[0]};
                    exp_n  = exp_r + EXP_ONE;
                end else if (!mant_r[HIDDEN] && (exp_r > EXP_ONE)) begin
                    mant_n = {mant_r[CARRY-1:0], 1'b0};
                    exp_n  = exp_r - EXP_ONE;
                end else begin
                    state_n = S_ROUND;
                end
            end

            S_ROUND: begin
                inexact_n = |mant_r[2:0];
                round_up  = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
                rnd_sum   = mant_r + {{(MANT_W-4){1'b0}}, round_up, 3'b000};
                if (rnd_sum[CARRY]) begin
                    mant_n = {1'b0, rnd_sum[CARRY:2], rnd_sum[1] | rnd_sum[0]};
                    exp_n  = exp_r + EXP_ONE;
                end else begin
                    mant_n = rnd_sum;
                end
                state_n = S_PACK;
            end

            S_PACK: begin
                if (nan_r) begin
                    r_n = 32'h7FC0_0000;
                end else if (mant_r == '0) begin
                    r_n = {sign_r, 31'b0};
                end else if (exp_r >= EXP_INF) begin
                    r_n   = {sign_r, 8'hFF, 23'b0};
                    ovf_n = 1'b1;
                end else begin
                    field = mant_r[HIDDEN] ? exp_r[7:0] : 8'h00;
                    r_n   = {sign_r, field, mant_r[HIDDEN-1:3]};
                    unf_n = (field == 8'h00) & inexact_r & (mant_r != '0);
                end
                done_n  = 1'b1;
                state_n = S_DONE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
            sign_r    <= 1'b0;
            nan_r     <= 1'b0;
            inexact_r <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            R         <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            start_q   <= start;
            armed_q   <= armed_n;
            sign_r    <= sign_n;
            nan_r     <= nan_n;
            inexact_r <= inexact_n;
            exp_r     <= exp_n;
            mant_r    <= mant_n;
            R         <= r_n;
            done      <= done_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end

endmodule
